// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the conv_block streaming front end.
//   state_t   : loader FSM states
//   n_w/n_d   : weight and data beat counts per load
//   cnt_width : beat counter width covering the larger of the two phases
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD_W    = 2'd0,
    LOAD_D    = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  function automatic int unsigned n_w(input int unsigned k);
    return k * k;
  endfunction

  function automatic int unsigned n_d(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  // Never narrower than one bit, even for a single-beat phase.
  function automatic int unsigned cnt_width(input int unsigned k,
                                            input int unsigned w,
                                            input int unsigned h);
    int unsigned m;
    m = (k * k > w * h) ? k * k : w * h;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/point_packer.sv
// Shift register that packs a stream of P-bit points into a flat N-point bus.
// The first point packed ends up at bits [0:P-1]; the newest sits in the LSBs.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   shift_en     : shift the bus up by one point and insert `point`
//   clear        : zero the bus (wins over shift_en)
//   point        : incoming point value
//   bus          : packed points, MSB-first indexing
module point_packer #(
  parameter int unsigned P = 8,
  parameter int unsigned N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           shift_en,
  input  logic           clear,
  input  logic [P-1:0]   point,
  output logic [0:P*N-1] bus
);

  localparam int unsigned BW = P * N;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus <= '0;
    end else if (clear) begin
      bus <= '0;
    end else if (shift_en) begin
      bus <= (bus << P) | BW'(point);
    end
  end

endmodule

// File: rtl/conv_frame_loader.sv
// Streaming loader for conv_block: packs K*K weights and a W*H frame from a
// valid/ready point stream, pulses start, then blocks until convolution_done.
// Ports:
//   clock, reset        : clock and asynchronous active-high reset
//   in_valid/in_ready   : point stream handshake (in_ready decoded from state)
//   in_point, in_last   : point value and end-of-frame marker (data phase only)
//   reuse_weights       : on the done cycle, skip the next weight phase
//   convolution_done    : completion from conv_block (used only in WAIT_DONE)
//   weights, data       : packed buses to conv_block
//   start               : one-cycle launch pulse
//   busy                : high in START and WAIT_DONE
//   frame_err           : one-cycle pulse on a framing violation
module conv_frame_loader
  import conv_pkg::*;
#(
  parameter int unsigned kernel_size = 2,
  parameter int unsigned data_width  = 4,
  parameter int unsigned data_height = 4,
  parameter int unsigned point_width = 8
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [point_width-1:0]                              in_point,
  input  logic                                                in_last,
  input  logic                                                reuse_weights,
  input  logic                                                convolution_done,
  output logic [0:point_width*kernel_size*kernel_size-1]      weights,
  output logic [0:point_width*data_width*data_height-1]       data,
  output logic                                                start,
  output logic                                                busy,
  output logic                                                frame_err
);

  localparam int unsigned N_W = n_w(kernel_size);
  localparam int unsigned N_D = n_d(data_width, data_height);
  localparam int unsigned CW  = cnt_width(kernel_size, data_width, data_height);
  localparam logic [CW-1:0] W_LAST = CW'(N_W - 1);
  localparam logic [CW-1:0] D_LAST = CW'(N_D - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          w_beat;
  logic          d_beat;
  logic          d_final;
  logic          d_bad;

  // Stream handshake decode.
  assign in_ready = (state == LOAD_W) || (state == LOAD_D);
  assign accept   = in_valid && in_ready;
  assign w_beat   = accept && (state == LOAD_W);
  assign d_beat   = accept && (state == LOAD_D);
  assign d_final  = (cnt == D_LAST);
  // in_last must coincide exactly with the final data beat.
  assign d_bad    = d_beat && (in_last != d_final);

  // Loader FSM, beat counter and registered strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= LOAD_W;
      cnt       <= '0;
      start     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      start     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        LOAD_W: begin
          if (w_beat) begin
            if (cnt == W_LAST) begin
              state <= LOAD_D;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        LOAD_D: begin
          if (d_beat) begin
            if (d_bad) begin
              frame_err <= 1'b1;
              cnt       <= '0;
            end else if (d_final) begin
              state <= START;
              cnt   <= '0;
              start <= 1'b1;
              busy  <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        START: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (convolution_done) begin
            state <= reuse_weights ? LOAD_D : LOAD_W;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= LOAD_W;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Weight bus packer.
  point_packer #(.P(point_width), .N(N_W)) u_weights (
    .clock    (clock),
    .reset    (reset),
    .shift_en (w_beat),
    .clear    (1'b0),
    .point    (in_point),
    .bus      (weights)
  );

  // Data bus packer; a framing violation discards the partial frame.
  point_packer #(.P(point_width), .N(N_D)) u_data (
    .clock    (clock),
    .reset    (reset),
    .shift_en (d_beat),
    .clear    (d_bad),
    .point    (in_point),
    .bus      (data)
  );

endmodule

// File: doc/conv_frame_loader.md
# conv_frame_loader

Streaming front end for `conv_block`. It accepts one point per beat over a valid/ready stream and packs the kernel weights and the input frame into `conv_block`'s flat `weights` and `data` buses. When both buses are full it pulses `start`. It then holds both buses stable and blocks the stream until `convolution_done` returns, after which it accepts the next frame. The block sits between the input DMA/stream source and `conv_block`.

## Interface
- `kernel_size`, default 2: kernel edge K; K*K weight points per load.
- `data_width`, default 4: frame width W in points.
- `data_height`, default 4: frame height H; W*H data points per frame.
- `point_width`, default 8: bits per point P.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `in_valid`  in  1: a point is presented on `in_point`.
- `in_ready`  out  1: loader accepts a point this cycle.
- `in_point`  in  P: point value.
- `in_last`  in  1: marks the final data point of a frame; ignored during the weight phase.
- `reuse_weights`  in  1: sampled on the `convolution_done` cycle. When 1, the next frame skips the weight phase.
- `convolution_done`  in  1: completion flag from `conv_block`.
- `weights`  out  [0:P*K*K-1]: packed kernel, driven to `conv_block.weights`.
- `data`  out  [0:P*W*H-1]: packed frame, driven to `conv_block.data`.
- `start`  out  1: one-cycle launch pulse to `conv_block`.
- `busy`  out  1: high in the START and WAIT_DONE states.
- `frame_err`  out  1: one-cycle pulse when the frame framing is violated.

## Operation
- A beat is accepted on a clock edge where `in_valid && in_ready`.
- `in_ready = 1` only in the LOAD_W and LOAD_D states. It is a combinational decode of the state and does not depend on `in_valid`.
- Packing order, for both buses: on each accepted beat, `bus <= (bus << P) | in_point`. After all beats, the first point received occupies bits [0:P-1] and the last point occupies the LSBs. This matches `conv_block`'s MSB-first indexing.
- The beat counter `cnt` has width clog2(max(K*K, W*H)). It is cleared on every state change.

States:
- LOAD_W: accept K*K weight beats. On the beat with `cnt == K*K-1`, move to LOAD_D.
- LOAD_D: accept W*H data beats.
  - Beat with `cnt == W*H-1` and `in_last == 1`: move to START.
  - `in_last == 1` on an earlier beat, or `in_last == 0` on beat W*H-1: pulse `frame_err`, clear `data`, move to LOAD_D. The weights are kept and no `start` is issued.
- START: `start = 1` for exactly one cycle, then move to WAIT_DONE.
- WAIT_DONE: hold `data` and `weights` unchanged. When `convolution_done == 1`, move to LOAD_D if `reuse_weights == 1`, otherwise to LOAD_W.
- `convolution_done` in any state other than WAIT_DONE is ignored.
- Outputs `data` and `weights` change only on accepted beats and on a framing-error clear.

## Timing
- Reset values:
  - state = LOAD_W; `cnt = 0`.
  - `data = 0`, `weights = 0`.
  - `start = 0`, `frame_err = 0`, `busy = 0`.
  - `in_ready = 1` as soon as reset deasserts.
- Maximum throughput is one beat per cycle with no bubble between the LOAD_W and LOAD_D phases.
- `start` is registered. It is high in the cycle after the edge that accepts the final data beat.
- `in_ready` falls in that same cycle. It rises in the cycle after the edge that samples `convolution_done == 1`.
- Minimum period from a frame's last beat to the next frame's first beat is 3 cycles: START, one WAIT_DONE cycle if `convolution_done` arrives immediately, then the next load cycle.
- `frame_err` is registered and high for the one cycle after the offending edge. A new frame can be accepted in that same cycle.
- Reset asserted mid-operation, including during WAIT_DONE, immediately returns all state to reset values. Any `conv_block` operation in flight is abandoned.
- The source may drop `in_valid` at any time. Stalls never corrupt `cnt`.

## Structure
- Shared package (`conv_pkg`):
  - state enum {LOAD_W, LOAD_D, START, WAIT_DONE}.
  - Localparam helper functions for N_W = K*K, N_D = W*H, and the counter width.
- The packing shift register is one natural sub-module: `point_packer`, with parameters P and N and inputs shift_en and clear. It is instantiated twice, once for weights and once for data.
- The FSM and counter live in the top module. Target size is about 150–250 lines.

## Test plan
- Nominal frame (K=2, W=H=4, P=8):
  - Send weights 1, 2, 3, 4, then data 0x00..0x0F with `in_last` on the 16th beat.
  - Expect `weights = 0x01020304` and `data = 0x000102…0F`.
  - Expect `start` to pulse once, one cycle after beat 16, and `busy = 1`.
- Backpressure and stall:
  - Randomly deassert `in_valid` during the nominal frame; expect identical bus values.
  - Hold `convolution_done` low for 20 cycles; expect `in_ready = 0` throughout, buses stable, and no further `start`.
- Early `in_last`:
  - Assert `in_last` on data beat 10.
  - Expect a one-cycle `frame_err` pulse, `data = 0`, the weights retained, no `start`, and `in_ready = 1` in the next cycle.
- Reuse weights:
  - Complete frame 1, then return `convolution_done` with `reuse_weights = 1`.
  - Expect the next 16 beats to load `data` only, with `weights` still 0x01020304.
  - Repeat with `reuse_weights = 0`; expect the weight phase to reload.
- Reset mid-load:
  - Assert `reset` after data beat 7.
  - Expect all outputs at reset values, state LOAD_W, and correct packing of a fresh full frame afterwards.
- Spurious `convolution_done`:
  - Pulse `convolution_done` during LOAD_D.
  - Expect no state change and no effect on `cnt`.
